// File: rtl/i2c_slave_regs.sv
// I2C target exposing a byte register file to an external master, with a local side port.
// Pins are synchronised and glitch-filtered; bits are sampled on filtered SCL rise and SDA is driven after filtered SCL fall.
module i2c_slave_regs #(
   parameter logic [6:0] DEV_ADDR   = 7'h50,
   parameter int         NUM_REGS   = 16,
   parameter int         FILTER_LEN = 4,
   localparam int        AW         = $clog2(NUM_REGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          scl_i,
   input  logic          sda_i,
   output logic          sda_o,
   output logic          sda_t,
   input  logic          lcl_wr_en,
   input  logic [AW-1:0] lcl_wr_addr,
   input  logic [7:0]    lcl_wr_data,
   input  logic [AW-1:0] lcl_rd_addr,
   output logic [7:0]    lcl_rd_data,
   output logic          bus_wr_valid,
   output logic [AW-1:0] bus_wr_addr,
   output logic [7:0]    bus_wr_data,
   output logic          busy
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
   } state_t;

   // Index 1 carries SCL, index 0 carries SDA through the synchroniser and filter.
   logic [1:0] pin_s1, pin_s2, pin_f, pin_f_d;
   logic [3:0] flt_cnt [2];

   state_t        state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          rw;
   logic [AW-1:0] ptr;
   logic [7:0]    regs [NUM_REGS];

   logic          scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
   logic [7:0]    rx_byte;
   logic [AW-1:0] ptr_nxt;

   assign sda_o     = 1'b0;
   assign scl_f     = pin_f[1];
   assign sda_f     = pin_f[0];
   assign scl_rise  = pin_f[1] & ~pin_f_d[1];
   assign scl_fall  = ~pin_f[1] & pin_f_d[1];
   assign start_det = scl_f & pin_f_d[1] & pin_f_d[0] & ~pin_f[0];
   assign stop_det  = scl_f & pin_f_d[1] & ~pin_f_d[0] & pin_f[0];
   assign rx_byte   = {shift[6:0], sda_f};
   assign ptr_nxt   = ptr + AW'(1);

   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         pin_s1  <= '1;
         pin_s2  <= '1;
         pin_f   <= '1;
         pin_f_d <= '1;
         for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
      end else begin
         pin_s1  <= {scl_i, sda_i};
         pin_s2  <= pin_s1;
         pin_f_d <= pin_f;
         for (int i = 0; i < 2; i++) begin
            if (pin_s2[i] == pin_f[i]) begin
               flt_cnt[i] <= '0;
            end else if (flt_cnt[i] == 4'(FILTER_LEN - 1)) begin
               pin_f[i]   <= pin_s2[i];
               flt_cnt[i] <= '0;
            end else begin
               flt_cnt[i] <= flt_cnt[i] + 4'd1;
            end
         end
      end
   end

   // NOTE: the register file must clear on reset, so it is built from flops rather than an inferred RAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         shift        <= '0;
         rw           <= 1'b0;
         ptr          <= '0;
         sda_t        <= 1'b1;
         busy         <= 1'b0;
         bus_wr_valid <= 1'b0;
         bus_wr_addr  <= '0;
         bus_wr_data  <= '0;
         lcl_rd_data  <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         bus_wr_valid <= 1'b0;
         lcl_rd_data  <= regs[lcl_rd_addr];
         // The bus write further down overrides a local write to the same index.
         if (lcl_wr_en) regs[lcl_wr_addr] <= lcl_wr_data;

         if (start_det) begin
            state   <= ADDR;
            bit_cnt <= '0;
            sda_t   <= 1'b1;
         end else if (stop_det) begin
            state <= IDLE;
            sda_t <= 1'b1;
            busy  <= 1'b0;
         end else if (scl_rise) begin
            case (state)
               ADDR, PTR, WDATA: begin
                  shift   <= rx_byte;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (state == ADDR) begin
                        if (rx_byte[7:1] == DEV_ADDR) begin
                           state <= ADDR_ACK;
                           busy  <= 1'b1;
                           rw    <= rx_byte[0];
                        end else begin
                           state <= IGNORE;
                           busy  <= 1'b0;
                        end
                     end else if (state == PTR) begin
                        ptr   <= rx_byte[AW-1:0];
                        state <= PTR_ACK;
                     end else begin
                        regs[ptr]    <= rx_byte;
                        bus_wr_valid <= 1'b1;
                        bus_wr_addr  <= ptr;
                        bus_wr_data  <= rx_byte;
                        ptr          <= ptr_nxt;
                        state        <= WDATA_ACK;
                     end
                  end
               end
               RDATA: begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= RDATA_ACK;
               end
               RDATA_ACK: begin
                  if (!sda_f) begin
                     ptr     <= ptr_nxt;
                     shift   <= regs[ptr_nxt];
                     bit_cnt <= '0;
                     state   <= RDATA;
                  end else begin
                     state <= IGNORE;
                     busy  <= 1'b0;
                  end
               end
               default: ;
            endcase
         end else if (scl_fall) begin
            case (state)
               ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                  // First fall starts our ACK, the second fall ends it and moves on.
                  if (sda_t) begin
                     sda_t <= 1'b0;
                  end else begin
                     sda_t   <= 1'b1;
                     bit_cnt <= '0;
                     if (state != ADDR_ACK) begin
                        state <= WDATA;
                     end else if (rw) begin
                        state <= RDATA;
                        shift <= {regs[ptr][6:0], 1'b0};
                        sda_t <= regs[ptr][7];
                     end else begin
                        state <= PTR;
                     end
                  end
               end
               RDATA: begin
                  sda_t <= shift[7];
                  shift <= {shift[6:0], 1'b0};
               end
               RDATA_ACK: sda_t <= 1'b1;
               default: ;
            endcase
         end
      end
   end

endmodule
